// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB constants and receive unstuffer state type; BIT_UNSTUFF_ERR_EN adds the ERROR state.
package usb_pkg;

  localparam int unsigned PID_BITS_DEF = 8;
  localparam int unsigned MAX_ONES_DEF = 6;

  // Transmit side: sync field and SE0 length of end-of-packet.
  localparam logic [7:0]  TX_SYNC_PATTERN = 8'b1000_0000;
  localparam int unsigned TX_EOP_SE0_BITS = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PID   = 3'd1,
    COUNT = 3'd2,
    STRIP = 3'd3
`ifdef BIT_UNSTUFF_ERR_EN
    , ERROR = 3'd4
`endif
  } unstuff_state_t;

endpackage

// File: rtl/bit_unstuffer_if.sv
// rtl/bit_unstuffer_if.sv - bit-level handshake between the NRZI decoder and the unstuffer.
interface bit_unstuffer_if;
  logic pkt_active;
  logic in_valid;
  logic in_bit;
  logic out_bit;
  logic out_valid;
  logic stuff_drop;
  logic stuff_err;
  logic busy;

  modport master (
    output pkt_active, in_valid, in_bit,
    input  out_bit, out_valid, stuff_drop, stuff_err, busy
  );

  modport slave (
    input  pkt_active, in_valid, in_bit,
    output out_bit, out_valid, stuff_drop, stuff_err, busy
  );
endinterface

// File: rtl/bit_unstuffer_fsm.sv
// rtl/bit_unstuffer_fsm.sv - unstuffer control FSM; BIT_UNSTUFF_ERR_EN enables the ERROR state.
module bit_unstuffer_fsm
  import usb_pkg::*;
#(
  parameter int unsigned PID_BITS = PID_BITS_DEF,
  parameter int unsigned MAX_ONES = MAX_ONES_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pkt_active,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic [2:0] bit_cnt,
  input  logic [2:0] ones_cnt,
  output logic       pass,
  output logic       drop,
  output logic       cnt_clr,
  output logic       bit_load,
  output logic       bit_inc,
  output logic       ones_load,
  output logic       ones_inc,
  output logic       ones_clr,
`ifdef BIT_UNSTUFF_ERR_EN
  output logic       err_set,
  output logic       err_clr,
`endif
  output logic       busy
);

  localparam logic [2:0] PID_LAST  = 3'(PID_BITS - 1);
  localparam logic [2:0] ONES_LAST = 3'(MAX_ONES - 1);

  unstuff_state_t state, state_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    pass       = 1'b0;
    drop       = 1'b0;
    cnt_clr    = 1'b0;
    bit_load   = 1'b0;
    bit_inc    = 1'b0;
    ones_load  = 1'b0;
    ones_inc   = 1'b0;
    ones_clr   = 1'b0;
`ifdef BIT_UNSTUFF_ERR_EN
    err_set    = 1'b0;
    err_clr    = 1'b0;
`endif
    // Packet end wins over everything, including a bit strobed in the same cycle.
    if (!pkt_active) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
    end else if (in_valid) begin
      unique case (state)
        IDLE: begin
          pass       = 1'b1;
          bit_load   = 1'b1;
          state_next = PID;
`ifdef BIT_UNSTUFF_ERR_EN
          err_clr    = 1'b1;
`endif
        end
        PID: begin
          pass    = 1'b1;
          bit_inc = 1'b1;
          if (bit_cnt == PID_LAST) begin
            ones_load  = 1'b1;
            state_next = COUNT;
          end
        end
        COUNT: begin
          pass = 1'b1;
          if (!in_bit) begin
            ones_clr = 1'b1;
          end else if (ones_cnt == ONES_LAST) begin
            ones_clr   = 1'b1;
            state_next = STRIP;
          end else begin
            ones_inc = 1'b1;
          end
        end
        STRIP: begin
          drop       = 1'b1;
          state_next = COUNT;
`ifdef BIT_UNSTUFF_ERR_EN
          if (in_bit) begin
            err_set    = 1'b1;
            state_next = ERROR;
          end
`endif
        end
`ifdef BIT_UNSTUFF_ERR_EN
        ERROR: begin
          state_next = ERROR;
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/bit_unstuffer.sv
// rtl/bit_unstuffer.sv - receive bit unstuffer datapath top; BIT_UNSTUFF_ERR_EN enables stuff_err.
module bit_unstuffer
  import usb_pkg::*;
#(
  parameter int unsigned PID_BITS = PID_BITS_DEF,
  parameter int unsigned MAX_ONES = MAX_ONES_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  bit_unstuffer_if.slave bus
);

  localparam logic [2:0] PID_LAST = 3'(PID_BITS - 1);

  logic [2:0] bit_cnt, ones_cnt;
  logic       pass, drop, cnt_clr, bit_load, bit_inc, ones_load, ones_inc, ones_clr;
  logic       out_bit_q, out_valid_q, stuff_drop_q;
`ifdef BIT_UNSTUFF_ERR_EN
  logic       err_set, err_clr, stuff_err_q;
`endif

  bit_unstuffer_fsm #(
    .PID_BITS (PID_BITS),
    .MAX_ONES (MAX_ONES)
  ) u_fsm (
    .clock      (clock),
    .reset_n    (reset_n),
    .pkt_active (bus.pkt_active),
    .in_valid   (bus.in_valid),
    .in_bit     (bus.in_bit),
    .bit_cnt    (bit_cnt),
    .ones_cnt   (ones_cnt),
    .pass       (pass),
    .drop       (drop),
    .cnt_clr    (cnt_clr),
    .bit_load   (bit_load),
    .bit_inc    (bit_inc),
    .ones_load  (ones_load),
    .ones_inc   (ones_inc),
    .ones_clr   (ones_clr),
`ifdef BIT_UNSTUFF_ERR_EN
    .err_set    (err_set),
    .err_clr    (err_clr),
`endif
    .busy       (bus.busy)
  );

  // bit_cnt saturates on the last PID bit so it can never wrap in long packets.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt      <= 3'd0;
      ones_cnt     <= 3'd0;
      out_bit_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      stuff_drop_q <= 1'b0;
    end else begin
      if (cnt_clr) begin
        bit_cnt  <= 3'd0;
        ones_cnt <= 3'd0;
      end else begin
        if (bit_load)                           bit_cnt <= 3'd1;
        else if (bit_inc && bit_cnt != PID_LAST) bit_cnt <= bit_cnt + 3'd1;
        if (ones_load)     ones_cnt <= {2'b00, bus.in_bit};
        else if (ones_inc) ones_cnt <= ones_cnt + 3'd1;
        else if (ones_clr) ones_cnt <= 3'd0;
      end
      out_valid_q  <= pass;
      stuff_drop_q <= drop;
      if (pass) out_bit_q <= bus.in_bit;
    end
  end

`ifdef BIT_UNSTUFF_ERR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     stuff_err_q <= 1'b0;
    else if (err_clr) stuff_err_q <= 1'b0;
    else if (err_set) stuff_err_q <= 1'b1;
  end
  assign bus.stuff_err = stuff_err_q;
`else
  assign bus.stuff_err = 1'b0;
`endif

  assign bus.out_bit    = out_bit_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.stuff_drop = stuff_drop_q;

endmodule

// File: tb/tb_bit_unstuffer.sv
// tb/tb_bit_unstuffer.sv - randomized self-checking bench for bit_unstuffer; follows BIT_UNSTUFF_ERR_EN.
module tb_bit_unstuffer;

  localparam int PB = 8;
  localparam int MO = 6;
`ifdef BIT_UNSTUFF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int A_NONE = 0;
  localparam int A_PASS = 1;
  localparam int A_DROP = 2;
  localparam int A_ERR  = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bit_unstuffer_if bus ();

  bit_unstuffer #(
    .PID_BITS (PB),
    .MAX_ONES (MO)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_ov = 0;
  int n_drop = 0;
  bit exp_ov, exp_ob, exp_drop, exp_err, exp_busy;
  bit pkt[$];
  int acts[$];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) pkt.push_back(v[k]);
  endtask

  // Reference: PID bits pass untouched, the last one seeds the run of ones;
  // after MO consecutive ones the next bit is the stuffed bit and is removed.
  function automatic void classify();
    int run;
    bit strip;
    bit err;
    run = 0;
    strip = 1'b0;
    err = 1'b0;
    acts.delete();
    for (int i = 0; i < pkt.size(); i++) begin
      if (err) begin
        acts.push_back(A_NONE);
      end else if (i < PB) begin
        acts.push_back(A_PASS);
        if (i == PB - 1) run = pkt[i] ? 1 : 0;
      end else if (strip) begin
        strip = 1'b0;
        if (pkt[i] && ERR_EN) begin
          err = 1'b1;
          acts.push_back(A_ERR);
        end else begin
          acts.push_back(A_DROP);
        end
      end else begin
        acts.push_back(A_PASS);
        run = pkt[i] ? run + 1 : 0;
        if (run == MO) begin
          strip = 1'b1;
          run = 0;
        end
      end
    end
  endfunction

  task automatic cyc(input bit pa, input bit v, input bit b, input int act, input bit first);
    @(negedge clock);
    check("out_valid", int'(bus.out_valid), int'(exp_ov));
    check("out_bit", int'(bus.out_bit), int'(exp_ob));
    check("stuff_drop", int'(bus.stuff_drop), int'(exp_drop));
    check("stuff_err", int'(bus.stuff_err), int'(exp_err));
    check("busy", int'(bus.busy), int'(exp_busy));
    n_ov   += int'(bus.out_valid);
    n_drop += int'(bus.stuff_drop);
    bus.pkt_active = pa;
    bus.in_valid   = v;
    bus.in_bit     = b;
    exp_ov   = pa && v && (act == A_PASS);
    if (exp_ov) exp_ob = b;
    exp_drop = pa && v && (act == A_DROP || act == A_ERR);
    if (!pa)    exp_busy = 1'b0;
    else if (v) exp_busy = 1'b1;
    if (pa && v && first)         exp_err = 1'b0;
    if (pa && v && act == A_ERR)  exp_err = 1'b1;
  endtask

  task automatic send_packet(input int gap, input bit rand_gap);
    int g;
    classify();
    for (int i = 0; i < pkt.size(); i++) begin
      g = rand_gap ? int'($urandom_range(gap, 0)) : gap;
      for (int k = 0; k < g; k++) cyc(1'b1, 1'b0, 1'b0, A_NONE, 1'b0);
      cyc(1'b1, 1'b1, pkt[i], acts[i], i == 0);
    end
    // A bit strobed as pkt_active falls must be discarded.
    cyc(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), A_NONE, 1'b0);
  endtask

  task automatic directed(input string name, input int gap, input int exp_outs, input int exp_drops);
    int s_ov, s_drop;
    s_ov = n_ov;
    s_drop = n_drop;
    send_packet(gap, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, A_NONE, 1'b0);
    check({name, "_outs"}, n_ov - s_ov, exp_outs);
    check({name, "_drops"}, n_drop - s_drop, exp_drops);
  endtask

  task automatic reset_mid_count();
    pkt.delete();
    add_bits(32'h00, PB);
    add_bits(32'hF, 4);
    classify();
    for (int i = 0; i < pkt.size(); i++) cyc(1'b1, 1'b1, pkt[i], acts[i], i == 0);
    cyc(1'b1, 1'b0, 1'b0, A_NONE, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_bit", int'(bus.out_bit), 0);
    check("rst_stuff_drop", int'(bus.stuff_drop), 0);
    check("rst_stuff_err", int'(bus.stuff_err), 0);
    check("rst_busy", int'(bus.busy), 0);
    bus.pkt_active = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_bit     = 1'b0;
    {exp_ov, exp_ob, exp_drop, exp_err, exp_busy} = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int len;
    bus.pkt_active = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_bit     = 1'b0;
    {exp_ov, exp_ob, exp_drop, exp_err, exp_busy} = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    pkt.delete(); add_bits(32'hF0, 8); add_bits(32'b101, 3);
    directed("pid_data", 0, 11, 0);

    pkt.delete(); add_bits(32'h00, 8); add_bits(32'b1111110, 7); add_bits(32'b10, 2);
    directed("six_ones", 0, 16, 1);

    pkt.delete(); add_bits(32'h01, 8); add_bits(32'b111110, 6); add_bits(32'b1, 1);
    directed("pid_cross", 0, 14, 1);

    pkt.delete(); add_bits(32'h00, 8); add_bits(32'b1111111, 7); add_bits(32'b101, 3);
    directed("stuff_one", 0, ERR_EN ? 14 : 17, 1);

    pkt.delete(); add_bits(32'h00, 8); add_bits(32'b1111110, 7); add_bits(32'b10, 2);
    directed("gapped", 2, 16, 1);

    pkt.delete(); add_bits(32'h00, 8); add_bits(32'b111111, 6);
    directed("end_in_strip", 0, 14, 0);

    reset_mid_count();
    pkt.delete(); add_bits(32'h01, 8); add_bits(32'b111110, 6); add_bits(32'b1, 1);
    directed("after_reset", 0, 14, 1);

    for (int p = 0; p < 40; p++) begin
      pkt.delete();
      len = int'($urandom_range(40, 8));
      for (int i = 0; i < len; i++) pkt.push_back($urandom_range(3, 0) != 0);
      send_packet(2, 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0, A_NONE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
